atm: RTL and testbench
======================

ATM -- requirements
Module: atm

Interface
REQ-001 SHALL have port clk, input, 1 bit, single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit, asynchronous active-low reset (0 = reset).
REQ-003 SHALL have port card, input, 1 bit, 1 = card inserted.
REQ-004 SHALL have port card_no, input, 3 bits, account number.
REQ-005 SHALL have port password, input, 4 bits, entered PIN.
REQ-006 SHALL have port option, input, 4 bits, menu selection: 1 deposit, 2 withdraw, 3 show balance.
REQ-007 SHALL have port language, input, 2 bits: 0 English, 1 Arabic, 2/3 invalid.
REQ-008 SHALL have port amount, input, 8 bits, unsigned transaction amount.
REQ-009 SHALL have port another_service, input, 1 bit, 1 = return to menu after a transaction.
REQ-010 SHALL have port avalaible_balance (spelling fixed), output, 8 bits, registered balance of the current account.
REQ-011 SHALL have ports invalid_password, invalid_card, no_balance, outputs, 1 bit each, registered one-cycle status pulses.

Function
REQ-012 SHALL hold four accounts (card_no 0..3) in an 8-bit balance register array; card_no 4..7 SHALL be invalid.
REQ-013 SHALL use fixed PINs: PIN = 4'hF minus card_no (acct0 1111, acct1 1110, acct2 1101, acct3 1100).
REQ-014 SHALL reset balances to acct0 50, acct1 100, acct2 80, acct3 20.
REQ-015 SHALL implement states IDLE, PIN, LANG, MENU, DEPOSIT, WITHDRAW, BALANCE, ANOTHER; one transition per clock.
REQ-016 IDLE: card=0 -> stay; card=1 and card_no<=3 -> latch card_no as current account, go PIN; card=1 and card_no>=4 -> invalid_card pulse, stay IDLE.
REQ-017 PIN: password matches current account PIN -> LANG; mismatch -> invalid_password pulse, go IDLE.
REQ-018 LANG: language 0 or 1 -> MENU; language 2 or 3 -> stay LANG.
REQ-019 MENU: option 1 -> DEPOSIT, 2 -> WITHDRAW, 3 -> BALANCE, any other value -> stay MENU.
REQ-020 DEPOSIT: balance <= min(balance+amount, 255) (saturating, 9-bit compare); avalaible_balance <= new balance; go ANOTHER.
REQ-021 WITHDRAW: amount <= balance -> balance <= balance-amount, avalaible_balance <= new balance; amount > balance -> balance unchanged, no_balance pulse, avalaible_balance <= balance; go ANOTHER.
REQ-022 WITHDRAW with amount == balance SHALL succeed, leaving 0; amount 0 SHALL succeed with no change.
REQ-023 BALANCE: avalaible_balance <= balance, go ANOTHER.
REQ-024 ANOTHER: another_service=1 -> MENU; 0 -> IDLE.
REQ-025 In any state other than IDLE, card=0 SHALL force IDLE next cycle with no balance update (card removal has priority over all other inputs).
REQ-026 Status pulses SHALL be high exactly one cycle, in the cycle after the triggering state, and 0 otherwise.
REQ-027 avalaible_balance SHALL be cleared to 0 on entry to IDLE and hold its value otherwise.
REQ-028 Only the latched current account SHALL be read or modified; card_no changes after IDLE SHALL be ignored.

Reset
REQ-029 rst=0 SHALL immediately (asynchronously) set state IDLE, all outputs 0, current account 0, balances to REQ-014 values.
REQ-030 Reset asserted mid-transaction SHALL abort it; a balance update not yet clocked SHALL not occur.
REQ-031 After rst returns to 1, first state evaluation SHALL occur on the next rising clk edge.

Verification
REQ-032 card=0 after reset -> FSM stays IDLE, all flags 0, avalaible_balance 0.
REQ-033 card=1, card_no=0, password=1110 -> invalid_password one-cycle pulse, back to IDLE.
REQ-034 card=1, card_no=1, password=1110, language=0, option=1, amount=4 -> avalaible_balance 104, acct1 balance 104.
REQ-035 card=1, card_no=2, password=1101, language=1, option=2, amount=1 -> avalaible_balance 79; then option=3 with another_service=1 -> 79 again.
REQ-036 card=1, card_no=3, password=1100, option=2, amount=128 -> no_balance pulse, avalaible_balance 20, balance unchanged; language=2 -> stalls in LANG.
REQ-037 card=1, card_no=4 -> invalid_card pulse; card dropped to 0 in MENU -> IDLE; random stimulus 1000 cycles -> no X on outputs, balances never wrap.

Source files
------------

// File: rtl/atm.sv
// -----------------------------------------------------------------------------
// atm - four-account automated teller state machine
//
// A card insertion latches the account, then the session walks through PIN
// check, language selection and a service menu (deposit / withdraw / show
// balance). Balances live in an on-chip register array. Deposits saturate at
// 255. A withdrawal that exceeds the balance is refused.
//
// Ports
//   clk               rising-edge clock
//   rst               asynchronous reset, active low
//   card              1 = card present; dropping it aborts any session
//   card_no[2:0]      account number, sampled only in IDLE (4..7 invalid)
//   password[3:0]     entered PIN (account n expects 4'hF - n)
//   option[3:0]       menu selection: 1 deposit, 2 withdraw, 3 balance
//   language[1:0]     0 English, 1 Arabic, 2/3 rejected (stay in LANG)
//   amount[7:0]       transaction amount
//   another_service   1 = back to MENU after a transaction, 0 = end session
//   avalaible_balance registered balance shown to the user, 0 while idle
//   invalid_password  one-cycle pulse after a wrong PIN
//   invalid_card      one-cycle pulse after an out-of-range card number
//   no_balance        one-cycle pulse after a refused withdrawal
// -----------------------------------------------------------------------------
module atm (
    input  logic       clk,
    input  logic       rst,
    input  logic       card,
    input  logic [2:0] card_no,
    input  logic [3:0] password,
    input  logic [3:0] option,
    input  logic [1:0] language,
    input  logic [7:0] amount,
    input  logic       another_service,
    output logic [7:0] avalaible_balance,
    output logic       invalid_password,
    output logic       invalid_card,
    output logic       no_balance
);

    typedef enum logic [2:0] {
        IDLE, PIN, LANG, MENU, DEPOSIT, WITHDRAW, BALANCE, ANOTHER
    } state_t;

    state_t     state, next_state;
    logic [1:0] cur_acct;
    logic [7:0] bal [4];

    logic [7:0] cur_bal;
    logic [8:0] dep_sum;
    logic [7:0] dep_new;
    logic [7:0] wd_new;
    logic [3:0] exp_pin;
    logic       wd_ok;

    // per-cycle actions decided by the FSM, applied by the datapath
    logic latch_acct, set_inv_card, set_inv_pw, set_no_bal;
    logic do_dep, do_wd, show_bal;

    assign cur_bal = bal[cur_acct];
    assign dep_sum = {1'b0, cur_bal} + {1'b0, amount};
    assign dep_new = dep_sum[8] ? 8'hFF : dep_sum[7:0];
    assign wd_new  = cur_bal - amount;
    assign wd_ok   = (amount <= cur_bal);
    assign exp_pin = 4'hF - {2'b00, cur_acct};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state   = state;
        latch_acct   = 1'b0;
        set_inv_card = 1'b0;
        set_inv_pw   = 1'b0;
        set_no_bal   = 1'b0;
        do_dep       = 1'b0;
        do_wd        = 1'b0;
        show_bal     = 1'b0;
        // card removal outranks every other input outside IDLE
        if (state != IDLE && !card) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (card) begin
                        if (!card_no[2]) begin
                            latch_acct = 1'b1;
                            next_state = PIN;
                        end else begin
                            set_inv_card = 1'b1;
                        end
                    end
                end
                PIN: begin
                    if (password == exp_pin) begin
                        next_state = LANG;
                    end else begin
                        set_inv_pw = 1'b1;
                        next_state = IDLE;
                    end
                end
                LANG: begin
                    if (!language[1]) next_state = MENU;
                end
                MENU: begin
                    case (option)
                        4'd1:    next_state = DEPOSIT;
                        4'd2:    next_state = WITHDRAW;
                        4'd3:    next_state = BALANCE;
                        default: next_state = MENU;
                    endcase
                end
                DEPOSIT: begin
                    do_dep     = 1'b1;
                    next_state = ANOTHER;
                end
                WITHDRAW: begin
                    if (wd_ok) do_wd      = 1'b1;
                    else       set_no_bal = 1'b1;
                    next_state = ANOTHER;
                end
                BALANCE: begin
                    show_bal   = 1'b1;
                    next_state = ANOTHER;
                end
                ANOTHER: begin
                    next_state = another_service ? MENU : IDLE;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_acct          <= 2'd0;
            bal[0]            <= 8'd50;
            bal[1]            <= 8'd100;
            bal[2]            <= 8'd80;
            bal[3]            <= 8'd20;
            avalaible_balance <= 8'd0;
            invalid_password  <= 1'b0;
            invalid_card      <= 1'b0;
            no_balance        <= 1'b0;
        end else begin
            invalid_card     <= set_inv_card;
            invalid_password <= set_inv_pw;
            no_balance       <= set_no_bal;
            if (latch_acct) cur_acct <= card_no[1:0];
            // the display is blanked whenever the session returns to IDLE
            if (next_state == IDLE) begin
                avalaible_balance <= 8'd0;
            end else if (do_dep) begin
                bal[cur_acct]     <= dep_new;
                avalaible_balance <= dep_new;
            end else if (do_wd) begin
                bal[cur_acct]     <= wd_new;
                avalaible_balance <= wd_new;
            end else if (set_no_bal || show_bal) begin
                avalaible_balance <= cur_bal;
            end
        end
    end

endmodule

// File: tb/tb_atm.sv
// -----------------------------------------------------------------------------
// tb_atm - directed and random checks of the atm block against a session-level
// model. The model advances once per clock from the same inputs; a negedge
// process compares every output every cycle, and directed steps pin the model
// with hand-computed literals.
// -----------------------------------------------------------------------------
module tb_atm;

    logic       clk;
    logic       rst;
    logic       card;
    logic [2:0] card_no;
    logic [3:0] password;
    logic [3:0] option;
    logic [1:0] language;
    logic [7:0] amount;
    logic       another_service;
    logic [7:0] avalaible_balance;
    logic       invalid_password;
    logic       invalid_card;
    logic       no_balance;

    atm dut (
        .clk               (clk),
        .rst               (rst),
        .card              (card),
        .card_no           (card_no),
        .password          (password),
        .option            (option),
        .language          (language),
        .amount            (amount),
        .another_service   (another_service),
        .avalaible_balance (avalaible_balance),
        .invalid_password  (invalid_password),
        .invalid_card      (invalid_card),
        .no_balance        (no_balance)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // ---------------- session model ----------------
    localparam int P_IDLE = 0, P_PIN = 1, P_LANG = 2, P_MENU = 3,
                   P_DEP = 4, P_WD = 5, P_BAL = 6, P_MORE = 7;
    int         m_phase;
    int         m_acct;
    int         m_bal [4];
    logic [7:0] e_av;
    logic       e_ip, e_ic, e_nb;

    function automatic void model_reset();
        m_phase = P_IDLE;
        m_acct  = 0;
        m_bal[0] = 50; m_bal[1] = 100; m_bal[2] = 80; m_bal[3] = 20;
        e_av = 8'd0; e_ip = 1'b0; e_ic = 1'b0; e_nb = 1'b0;
    endfunction

    function automatic void model_step();
        int s;
        e_ip = 1'b0; e_ic = 1'b0; e_nb = 1'b0;
        if (m_phase != P_IDLE && card == 1'b0) begin
            m_phase = P_IDLE;
        end else if (m_phase == P_IDLE) begin
            if (card) begin
                if (int'(card_no) < 4) begin
                    m_acct  = int'(card_no);
                    m_phase = P_PIN;
                end else begin
                    e_ic = 1'b1;
                end
            end
        end else if (m_phase == P_PIN) begin
            if (int'(password) == 15 - m_acct) m_phase = P_LANG;
            else begin e_ip = 1'b1; m_phase = P_IDLE; end
        end else if (m_phase == P_LANG) begin
            if (int'(language) <= 1) m_phase = P_MENU;
        end else if (m_phase == P_MENU) begin
            if (option == 4'd1)      m_phase = P_DEP;
            else if (option == 4'd2) m_phase = P_WD;
            else if (option == 4'd3) m_phase = P_BAL;
        end else if (m_phase == P_DEP) begin
            s = m_bal[m_acct] + int'(amount);
            if (s > 255) s = 255;
            m_bal[m_acct] = s;
            e_av = 8'(s);
            m_phase = P_MORE;
        end else if (m_phase == P_WD) begin
            if (int'(amount) <= m_bal[m_acct]) m_bal[m_acct] = m_bal[m_acct] - int'(amount);
            else e_nb = 1'b1;
            e_av = 8'(m_bal[m_acct]);
            m_phase = P_MORE;
        end else if (m_phase == P_BAL) begin
            e_av = 8'(m_bal[m_acct]);
            m_phase = P_MORE;
        end else begin
            m_phase = another_service ? P_MENU : P_IDLE;
        end
        if (m_phase == P_IDLE) e_av = 8'd0;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("no_x", int'($isunknown({avalaible_balance, invalid_password,
                                           invalid_card, no_balance})), 0);
            check("avail_vs_model", int'(avalaible_balance), int'(e_av));
            check("inv_pw_vs_model", int'(invalid_password), int'(e_ip));
            check("inv_card_vs_model", int'(invalid_card), int'(e_ic));
            check("no_bal_vs_model", int'(no_balance), int'(e_nb));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input logic c, input logic [2:0] cn, input logic [3:0] pw,
                         input logic [1:0] lg, input logic [3:0] op,
                         input logic [7:0] am, input logic an);
        card = c; card_no = cn; password = pw; language = lg;
        option = op; amount = am; another_service = an;
        tick();
    endtask

    task automatic do_reset(input bit immediate_chk);
        rst = 1'b0;
        model_reset();
        #1;
        if (immediate_chk) begin
            check("async_rst_avail", int'(avalaible_balance), 0);
            check("async_rst_flags", int'({invalid_password, invalid_card, no_balance}), 0);
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        card = 0; card_no = 0; password = 0; language = 0;
        option = 0; amount = 0; another_service = 0;
        do_reset(1'b0);
        chk_en = 1'b1;

        // idle with no card
        repeat (3) drive(0, 3'd0, 4'h0, 2'd0, 4'd0, 8'd0, 0);
        check("idle_avail", int'(avalaible_balance), 0);
        check("idle_flags", int'({invalid_password, invalid_card, no_balance}), 0);

        // wrong PIN on account 0
        drive(1, 3'd0, 4'b1110, 2'd0, 4'd0, 8'd0, 0);
        drive(1, 3'd0, 4'b1110, 2'd0, 4'd0, 8'd0, 0);
        check("bad_pin_pulse", int'(invalid_password), 1);
        drive(0, 3'd0, 4'b1110, 2'd0, 4'd0, 8'd0, 0);
        check("bad_pin_pulse_end", int'(invalid_password), 0);

        // deposit 4 to account 1: IDLE,PIN,LANG,MENU,DEPOSIT
        repeat (5) drive(1, 3'd1, 4'b1110, 2'd0, 4'd1, 8'd4, 0);
        check("dep_avail_104", int'(avalaible_balance), 104);
        check("model_acct1_104", m_bal[1], 104);
        drive(1, 3'd1, 4'b1110, 2'd0, 4'd1, 8'd4, 0);
        check("session_end_clear", int'(avalaible_balance), 0);

        // withdraw 1 from account 2 then show balance
        repeat (5) drive(1, 3'd2, 4'b1101, 2'd1, 4'd2, 8'd1, 0);
        check("wd_avail_79", int'(avalaible_balance), 79);
        drive(1, 3'd2, 4'b1101, 2'd1, 4'd3, 8'd1, 1);
        drive(1, 3'd2, 4'b1101, 2'd1, 4'd3, 8'd1, 1);
        drive(1, 3'd2, 4'b1101, 2'd1, 4'd3, 8'd1, 1);
        check("bal_avail_79", int'(avalaible_balance), 79);
        drive(1, 3'd2, 4'b1101, 2'd1, 4'd3, 8'd1, 0);

        // account 3: stall in LANG, then over-withdraw
        repeat (2) drive(1, 3'd3, 4'b1100, 2'd2, 4'd2, 8'd128, 0);
        repeat (3) drive(1, 3'd3, 4'b1100, 2'd2, 4'd2, 8'd128, 0);
        check("lang_stall_avail", int'(avalaible_balance), 0);
        drive(1, 3'd3, 4'b1100, 2'd0, 4'd2, 8'd128, 0);  // LANG -> MENU
        drive(1, 3'd3, 4'b1100, 2'd0, 4'd2, 8'd128, 0);  // MENU -> WITHDRAW
        drive(1, 3'd3, 4'b1100, 2'd0, 4'd2, 8'd128, 1);  // refused
        check("no_bal_pulse", int'(no_balance), 1);
        check("no_bal_avail_20", int'(avalaible_balance), 20);
        drive(1, 3'd3, 4'b1100, 2'd0, 4'd2, 8'd20, 1);   // ANOTHER -> MENU
        check("no_bal_pulse_end", int'(no_balance), 0);
        drive(1, 3'd3, 4'b1100, 2'd0, 4'd2, 8'd20, 1);   // MENU -> WITHDRAW
        drive(1, 3'd3, 4'b1100, 2'd0, 4'd2, 8'd20, 1);   // exact balance
        check("wd_exact_0", int'(avalaible_balance), 0);
        check("wd_exact_flag", int'(no_balance), 0);
        drive(1, 3'd3, 4'b1100, 2'd0, 4'd2, 8'd0, 1);
        drive(1, 3'd3, 4'b1100, 2'd0, 4'd2, 8'd0, 1);
        drive(1, 3'd3, 4'b1100, 2'd0, 4'd2, 8'd0, 0);    // withdraw 0 from 0
        check("wd_zero_flag", int'(no_balance), 0);
        check("model_acct3_0", m_bal[3], 0);
        drive(1, 3'd3, 4'b1100, 2'd0, 4'd2, 8'd0, 0);

        // deposit saturation on account 0: 50 + 250 -> 255
        repeat (5) drive(1, 3'd0, 4'b1111, 2'd0, 4'd1, 8'd250, 0);
        check("dep_saturate_255", int'(avalaible_balance), 255);
        drive(1, 3'd0, 4'b1111, 2'd0, 4'd1, 8'd250, 0);

        // invalid card
        drive(1, 3'd4, 4'b1111, 2'd0, 4'd0, 8'd0, 0);
        check("inv_card_pulse", int'(invalid_card), 1);
        drive(0, 3'd4, 4'b1111, 2'd0, 4'd0, 8'd0, 0);
        check("inv_card_pulse_end", int'(invalid_card), 0);

        // card pulled in MENU: no deposit may happen
        repeat (3) drive(1, 3'd1, 4'b1110, 2'd0, 4'd0, 8'd9, 0);
        drive(0, 3'd1, 4'b1110, 2'd0, 4'd1, 8'd9, 0);
        drive(1, 3'd1, 4'b1110, 2'd0, 4'd1, 8'd9, 0);   // fresh session
        check("model_acct1_still_104", m_bal[1], 104);

        // card_no changes after IDLE are ignored; balance query shows acct 1
        drive(1, 3'd3, 4'b1110, 2'd0, 4'd3, 8'd200, 1); // PIN (acct 1 latched)
        drive(1, 3'd3, 4'b1110, 2'd0, 4'd3, 8'd200, 1); // LANG
        drive(1, 3'd3, 4'b1110, 2'd0, 4'd3, 8'd200, 1); // MENU
        drive(1, 3'd3, 4'b1110, 2'd0, 4'd3, 8'd200, 1); // BALANCE
        check("latched_acct_104", int'(avalaible_balance), 104);
        drive(1, 3'd3, 4'b1110, 2'd0, 4'd1, 8'd200, 1); // ANOTHER -> MENU
        drive(1, 3'd3, 4'b1110, 2'd0, 4'd1, 8'd200, 1); // MENU -> DEPOSIT

        // reset lands while in DEPOSIT: must clear at once and drop the deposit
        do_reset(1'b1);
        repeat (4) drive(1, 3'd1, 4'b1110, 2'd0, 4'd3, 8'd0, 0);
        drive(1, 3'd1, 4'b1110, 2'd0, 4'd3, 8'd0, 0);
        check("post_reset_acct1_100", int'(avalaible_balance), 100);
        drive(0, 3'd1, 4'b1110, 2'd0, 4'd3, 8'd0, 0);

        // random soak
        for (int i = 0; i < 1000; i++) begin
            logic c;
            logic [3:0] pw;
            c  = ($urandom_range(0, 15) != 0);
            pw = ($urandom_range(0, 3) != 0) ? 4'(15 - m_acct) : 4'($urandom_range(0, 15));
            drive(c, 3'($urandom_range(0, 7)), pw, 2'($urandom_range(0, 3)),
                  4'($urandom_range(0, 4)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)));
        end
        for (int a = 0; a < 4; a++) check("model_bal_range", int'(m_bal[a] >= 0 && m_bal[a] <= 255), 1);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
